// File: rtl/ula_serial_ctrl.sv
// rtl/ula_serial_ctrl.sv - bit-serial controller walking one 1-bit ula slice LSB to MSB.
// Carries between bits through a registered cout; SLT bit is resolved in a fix-up cycle.

module ula_slice (
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_cin,
  input  logic       i_addsub,
  input  logic       i_less,
  input  logic [2:0] i_op,
  output logic       o_saida,
  output logic       o_cout,
  output logic       o_set
);
  logic w_b;
  logic w_sum;

  assign w_b    = i_b ^ i_addsub;
  assign w_sum  = i_a ^ w_b ^ i_cin;
  assign o_cout = (i_a & w_b) | (i_a & i_cin) | (w_b & i_cin);
  assign o_set  = w_sum;

  always_comb begin
    o_saida = 1'b0;
    case (i_op)
      3'b000:  o_saida = i_a & i_b;
      3'b001:  o_saida = i_a | i_b;
      3'b010:  o_saida = w_sum;
      3'b011:  o_saida = ~(i_a | i_b);
      3'b101:  o_saida = i_a ^ i_b;
      3'b110:  o_saida = w_sum;
      3'b111:  o_saida = i_less;
      default: o_saida = 1'b0;
    endcase
  end
endmodule

module ula_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       ULAcontrole,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resultado,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_carry;
  logic             r_set;

  logic             w_addsub;
  logic             w_arith;
  logic             w_last;
  logic             w_cin;
  logic             w_sai;
  logic             w_cout;
  logic             w_set;
  logic [WIDTH-1:0] w_fix_res;

  assign w_addsub = (r_op == 3'b110) || (r_op == 3'b111);
  assign w_arith  = (r_op == 3'b010) || w_addsub;
  assign w_last   = (r_idx == IW'(WIDTH - 1));
  assign w_cin    = (r_idx == '0) ? w_addsub : r_carry;

  ula_slice u_slice (
    .i_a      (r_a[r_idx]),
    .i_b      (r_b[r_idx]),
    .i_cin    (w_cin),
    .i_addsub (w_addsub),
    .i_less   (1'b0),
    .i_op     (r_op),
    .o_saida  (w_sai),
    .o_cout   (w_cout),
    .o_set    (w_set)
  );

  // SLT: sign of the difference corrected by overflow gives the true signed less-than.
  always_comb begin
    w_fix_res = resultado;
    if (r_op == 3'b111) w_fix_res[0] = r_set ^ overflow;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_carry   <= 1'b0;
      r_set     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      resultado <= '0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a       <= a;
            r_b       <= b;
            r_op      <= ULAcontrole;
            r_idx     <= '0;
            r_carry   <= 1'b0;
            resultado <= '0;
            zero      <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b1;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          resultado[r_idx] <= w_sai;
          r_carry          <= w_cout;
          if (w_last) begin
            carry_out <= w_cout;
            overflow  <= w_cin ^ w_cout;
            r_set     <= w_set;
            r_state   <= S_FIX;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        S_FIX: begin
          resultado <= w_fix_res;
          zero      <= (w_fix_res == '0);
          if (!w_arith) begin
            carry_out <= 1'b0;
            overflow  <= 1'b0;
          end
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ula_serial_ctrl.sv
// tb/tb_ula_serial_ctrl.sv - scoreboard bench for ula_serial_ctrl against an arithmetic reference model.
module tb_ula_serial_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, zero, carry_out, overflow;
  logic [W-1:0] resultado;

  ula_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ULAcontrole(op), .a(a), .b(b),
    .busy(busy), .done(done), .resultado(resultado), .zero(zero),
    .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [W:0] s, d;
    logic sv, dv;
    s  = {1'b0, x} + {1'b0, y};
    d  = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    sv = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    dv = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
    e = '0;
    case (o)
      3'd0: e.res = x & y;
      3'd1: e.res = x | y;
      3'd2: begin e.res = s[W-1:0]; e.c = s[W]; e.v = sv; end
      3'd3: e.res = ~(x | y);
      3'd5: e.res = x ^ y;
      3'd6: begin e.res = d[W-1:0]; e.c = d[W]; e.v = dv; end
      3'd7: begin e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0); e.c = d[W]; e.v = dv; end
      default: e.res = '0;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done with resultado %0h expected no done", resultado);
        end else begin
          mon_e = sb_q.pop_front();
          chk("resultado", 64'(resultado), 64'(mon_e.res));
          chk("carry_out", 64'(carry_out), 64'(mon_e.c));
          chk("overflow",  64'(overflow),  64'(mon_e.v));
          chk("zero",      64'(zero),      64'(mon_e.z));
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_done"},      64'(done),      64'd0);
    chk({tag, "_resultado"}, 64'(resultado), 64'd0);
    chk({tag, "_zero"},      64'(zero),      64'd0);
    chk({tag, "_carry"},     64'(carry_out), 64'd0);
    chk({tag, "_ovf"},       64'(overflow),  64'd0);
  endtask

  // Entered and left on a negedge; inputs are scrambled after accept.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int inj_at, input int rst_at);
    int cnt;
    bit got;
    start = 1'b1; op = o; a = x; b = y;
    sb_q.push_back(model(o, x, y));
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 100) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom; op = 3'($urandom);
      if (cnt == 1) chk("busy_run", 64'(busy), 64'd1);
      if (cnt == inj_at) start = 1'b1;
      if (cnt == rst_at) begin
        reset_n = 1'b0;
        #1;
        chk_all_zero("midrun_reset");
        sb_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        return;
      end
      if (done === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles expected 34", cnt);
    end else begin
      chk("latency", 64'(cnt), 64'd34);
    end
    @(negedge clk);
    chk("done_single", 64'(done), 64'd0);
    chk("busy_idle",   64'(busy), 64'd0);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] edges [6];
    edges[0] = 32'h0000_0000; edges[1] = 32'hFFFF_FFFF; edges[2] = 32'h7FFF_FFFF;
    edges[3] = 32'h8000_0000; edges[4] = 32'h0000_0001; edges[5] = 32'hFFFF_FFFE;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    run_op(3'b010, 32'd5, 32'd7, -1, -1);
    run_op(3'b110, 32'd3, 32'd5, -1, -1);
    run_op(3'b110, 32'd5, 32'd5, -1, -1);
    run_op(3'b111, 32'hFFFF_FFFF, 32'd1, -1, -1);
    run_op(3'b111, 32'h7FFF_FFFF, 32'h8000_0000, -1, -1);
    run_op(3'b010, 32'h7FFF_FFFF, 32'd1, -1, -1);
    run_op(3'b000, 32'hF0F0_A5A5, 32'h0FF0_FFFF, -1, -1);
    run_op(3'b001, 32'hF0F0_A5A5, 32'h0FF0_FFFF, -1, -1);
    run_op(3'b011, 32'hF0F0_A5A5, 32'h0FF0_FFFF, -1, -1);
    run_op(3'b101, 32'hF0F0_A5A5, 32'h0FF0_FFFF, -1, -1);
    run_op(3'b100, 32'hF0F0_A5A5, 32'h0FF0_FFFF, -1, -1);
    run_op(3'b010, 32'h1234_5678, 32'h0F0F_0F0F, 15, -1);
    run_op(3'b010, 32'hDEAD_BEEF, 32'h1111_1111, -1, 11);
    run_op(3'b010, 32'd1, 32'd1, -1, -1);
    for (int k = 0; k < 40; k++) begin
      run_op(3'($urandom), pick(), pick(), -1, -1);
    end
    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1000000");
    $fatal(1, "watchdog");
  end
endmodule
